cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Parametrised, buffered successor to the combinational two-source CDB merge. It accepts write-back results from N_SRC producers (RS ALU, LSB, future units) into per-source FIFOs. Each cycle it arbitrates among the FIFOs and broadcasts one result on a registered CDB to RoB, RS and LSB. Producers never lose a result to a collision, and flush discards all in-flight results.

Parameters:
N_SRC, 4, number of producer channels (2..8)
ROB_WIDTH, 3, RoB index width
DATA_W, 32, result data width
BUF_DEPTH, 2, entries per source FIFO (power of two, >=2)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest source index wins)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global pause; all state frozen while low
flush_signal  input  1  RoB mispredict flush, synchronous
src_valid  input  N_SRC  per-source result valid
src_index  input  N_SRC*ROB_WIDTH  RoB index, source i at bits [i*ROB_WIDTH +: ROB_WIDTH]
src_data  input  N_SRC*DATA_W  result data, source i at [i*DATA_W +: DATA_W]
src_ready  output  N_SRC  FIFO i can accept this cycle
cdb_en  output  1  broadcast valid
cdb_index  output  ROB_WIDTH  broadcast RoB index
cdb_data  output  DATA_W  broadcast data
cdb_src  output  clog2(N_SRC)  granted source (debug)

Behaviour:
- Reset (rst_in low, async):
  - all FIFOs empty, rr_ptr = 0
  - cdb_en = 0, cdb_index = 0, cdb_data = 0, cdb_src = 0
  - src_ready = all ones (combinational from counts)
- src_ready[i] = (count[i] != BUF_DEPTH). It is a function of the current count only, with no same-cycle pop credit.
- Push: at a rising edge with rdy_in high, flush_signal low, and src_valid[i] & src_ready[i], the {index, data} pair is written at the tail of FIFO i.
  - src_valid[i] while src_ready[i] is low is a protocol violation; the data is dropped and a simulation assertion fires.
- Eligibility: an entry pushed at edge t is eligible for arbitration in the cycle after t. There is no input-to-CDB bypass, so the minimum latency from src_valid to cdb_en is 2 edges.
- Arbitration is combinational over non-empty FIFOs, every cycle with rdy_in high and flush_signal low.
  - ARB_MODE 0: scan i = rr_ptr, rr_ptr+1, ... mod N_SRC; the first non-empty FIFO wins. On a grant, rr_ptr <= (winner+1) mod N_SRC. With no grant, rr_ptr holds.
  - ARB_MODE 1: the lowest non-empty index wins; rr_ptr is unused and stays 0.
- Broadcast register, at the edge:
  - With a grant: cdb_en <= 1, cdb_index/cdb_data <= head of the winning FIFO, cdb_src <= winner. The winner's head pops.
  - Without a grant: cdb_en <= 0, and cdb_index/cdb_data/cdb_src hold their previous values.
- Push and pop on the same FIFO in the same edge are both performed; the count is unchanged.
- FIFO pointers wrap modulo BUF_DEPTH. Full and empty are distinguished by count (width clog2(BUF_DEPTH)+1).
- Flush (flush_signal high at an edge with rdy_in high):
  - all FIFO counts and pointers go to 0, rr_ptr <= 0, cdb_en <= 0
  - pushes presented in the same cycle are discarded
  - no grant is made in the flush cycle
  - src_ready reads all ones in the following cycle
- rdy_in low: no push, pop, pointer or output change; outputs hold their last values, including cdb_en. Flush is ignored while rdy_in is low.
- Reset asserted mid-operation overrides everything asynchronously. Release is synchronised externally; no internal requirement beyond that.
- Throughput: one broadcast per cycle while any FIFO is non-empty. Within one source, results leave in FIFO order; order across sources follows arbitration.

Test Plan:
- Reset:
  - Stimulus: hold rst_in low for 3 cycles with src_valid = 4'b1111, then release.
  - Required: during reset cdb_en = 0, cdb_index = 0, cdb_data = 0, src_ready = 4'b1111. The first cdb_en = 1 appears 2 edges after release, with cdb_src = 0.
- Round-robin fairness (ARB_MODE 0):
  - Stimulus: a single edge pushes sources 0..3 with index = i, data = 32'hA0+i.
  - Required: cdb_src is 0, 1, 2, 3 on 4 consecutive cycles with the matching data, then cdb_en = 0.
  - Stimulus: next, push only source 2 once.
  - Required: it is granted; rr_ptr becomes 3.
- Backpressure (BUF_DEPTH 2):
  - Stimulus: hold src_valid[1] = 1 continuously with incrementing data 1, 2, 3, ...
  - Required: src_ready[1] never deasserts, since draining matches the fill rate. No data is lost or duplicated, and cdb_data increments by 1 each cycle.
- Fixed priority (ARB_MODE 1):
  - Stimulus: keep sources 0 and 3 continuously valid.
  - Required: only source 0 is granted while it stays valid. src_ready[3] drops after 2 pushes. When source 0 stops, source 3's entries emerge in push order.
- Flush:
  - Stimulus: fill FIFOs 0 and 1 to 2 entries each, then assert flush_signal for 1 cycle while also presenting src_valid[2].
  - Required: the next cycle shows cdb_en = 0 and src_ready = all ones. No stale entry or source-2 entry is ever broadcast.
- Pause:
  - Stimulus: drop rdy_in for 5 cycles while 3 entries are pending, with cdb_en = 1 and cdb_data = 32'h55.
  - Required: cdb_en, cdb_data = 32'h55 and src_ready are frozen for all 5 cycles. After rdy_in rises, the remaining entries drain in the same order as an unpaused run.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Buffered CDB arbiter: one FIFO per producer, one registered broadcast per cycle.
// Arbitration is round-robin (ARB_MODE 0) or fixed priority, lowest index first (ARB_MODE 1).

// Per-source result FIFO. Storage has no reset; the pointers and the count
// decide what is valid. Push, pop and clear arrive already qualified by the top.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 35
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // next pointers and count; a same-edge push and pop leave the count unchanged
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  // pointer and count state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

module cdb_arbiter #(
  parameter int N_SRC     = 4,
  parameter int ROB_WIDTH = 3,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int ARB_MODE  = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush_signal,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*ROB_WIDTH-1:0]    src_index,
  input  logic [N_SRC*DATA_W-1:0]       src_data,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          cdb_en,
  output logic [ROB_WIDTH-1:0]          cdb_index,
  output logic [DATA_W-1:0]             cdb_data,
  output logic [$clog2(N_SRC)-1:0]      cdb_src
);
  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = ROB_WIDTH + DATA_W;

  logic [N_SRC-1:0][CW-1:0] cnt;
  logic [N_SRC-1:0][EW-1:0] head;
  logic [N_SRC-1:0]         push, pop, nonempty;
  logic                     clr, gnt;
  logic [SW-1:0]            win;

  logic [SW-1:0]        rr_q, rr_d;
  logic                 en_q, en_d;
  logic [ROB_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [SW-1:0]        src_q, src_d;

  assign clr = rdy_in && flush_signal;

  // k-th candidate of the scan that starts at base, modulo N_SRC
  function automatic logic [SW-1:0] scan_idx(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_SRC) s = s - N_SRC;
    return SW'(s);
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [EW-1:0] din;
    assign din          = {src_index[i*ROB_WIDTH +: ROB_WIDTH], src_data[i*DATA_W +: DATA_W]};
    assign src_ready[i] = (cnt[i] != CW'(BUF_DEPTH));
    assign nonempty[i]  = (cnt[i] != '0);
    assign push[i]      = rdy_in && !flush_signal && src_valid[i] && src_ready[i];

    cdb_src_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr    (clr),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (din),
      .dout   (head[i]),
      .count  (cnt[i])
    );

    // a producer must not present a result to a full FIFO
    a_no_push_full: assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && !flush_signal && src_valid[i]) |-> src_ready[i]);
  end

  // pick the first non-empty FIFO starting at rr_ptr (or at 0 for fixed priority)
  always_comb begin
    logic [SW-1:0] base;
    logic [SW-1:0] c;
    gnt  = 1'b0;
    win  = '0;
    pop  = '0;
    base = (ARB_MODE == 1) ? '0 : rr_q;
    c    = '0;
    if (rdy_in && !flush_signal) begin
      for (int k = 0; k < N_SRC; k++) begin
        c = scan_idx(base, k);
        if (!gnt && nonempty[c]) begin
          gnt = 1'b1;
          win = c;
        end
      end
    end
    if (gnt) pop[win] = 1'b1;
  end

  // next round-robin pointer and broadcast register contents
  always_comb begin
    rr_d   = rr_q;
    en_d   = en_q;
    idx_d  = idx_q;
    data_d = data_q;
    src_d  = src_q;
    if (rdy_in) begin
      if (flush_signal) begin
        rr_d = '0;
        en_d = 1'b0;
      end else begin
        en_d = gnt;
        if (gnt) begin
          idx_d  = head[win][DATA_W +: ROB_WIDTH];
          data_d = head[win][DATA_W-1:0];
          src_d  = win;
          if (ARB_MODE == 0) rr_d = (win == SW'(N_SRC - 1)) ? '0 : win + SW'(1);
        end
      end
    end
  end

  // pointer and registered CDB
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_q   <= '0;
      en_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      en_q   <= en_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign cdb_en    = en_q;
  assign cdb_index = idx_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a round-robin and a fixed-priority instance share stimulus;
// per-source scoreboards check every broadcast, directed checks cover ordering.
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_signal;
  logic [3:0]       v0, v1;
  logic [3:0][2:0]  ix;
  logic [3:0][31:0] dt;

  logic [3:0]  rdy0, rdy1;
  logic        en0, en1;
  logic [2:0]  idx0, idx1;
  logic [31:0] data0, data1;
  logic [1:0]  src0, src1;

  int checks = 0;
  int errors = 0;
  bit act = 1'b0;
  int n3;
  int ord [4] = '{3, 0, 1, 2};

  logic [34:0] sb [8][$];
  logic [33:0] log1 [$];

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.ARB_MODE(0)) u_rr (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .src_valid(v0), .src_index(ix), .src_data(dt), .src_ready(rdy0),
    .cdb_en(en0), .cdb_index(idx0), .cdb_data(data0), .cdb_src(src0));

  cdb_arbiter #(.ARB_MODE(1)) u_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .src_valid(v1), .src_index(ix), .src_data(dt), .src_ready(rdy1),
    .cdb_en(en1), .cdb_index(idx1), .cdb_data(data1), .cdb_src(src1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // present a result on source i to each instance only if that instance can take it
  task automatic drv(input int i, input logic [31:0] d);
    ix[i] = 3'(i);
    dt[i] = d;
    v0[i] = rdy0[i];
    v1[i] = rdy1[i];
  endtask

  task automatic mon(input int d, input logic en, input logic [2:0] io,
                     input logic [31:0] dout, input logic [1:0] s);
    int k;
    k = d * 4 + int'(s);
    if (act && en) begin
      if (d == 1) log1.push_back({s, dout});
      if (sb[k].size() == 0) chk(d == 0 ? "sb_unexp_rr" : "sb_unexp_fp", 64'(sb[k].size()), 64'd1);
      else chk(d == 0 ? "sb_data_rr" : "sb_data_fp", 64'({io, dout}), 64'(sb[k].pop_front()));
    end
  endtask

  task automatic acct(input int d, input logic [3:0] v, input logic [3:0] r);
    if (rst_in && rdy_in) begin
      for (int i = 0; i < 4; i++) begin
        if (flush_signal) sb[d*4+i].delete();
        else if (v[i] && r[i]) sb[d*4+i].push_back({ix[i], dt[i]});
      end
    end
  endtask

  // scoreboard: pop on each new broadcast, push on each accepted result for the next edge
  always @(negedge clk_in) begin
    mon(0, en0, idx0, data0, src0);
    mon(1, en1, idx1, data1, src1);
    acct(0, v0, rdy0);
    acct(1, v1, rdy1);
    act = rst_in && rdy_in;
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ix[i] = 3'(i); dt[i] = 32'h100 + 32'(i);
    end
    v0 = 4'hF; v1 = 4'hF;

    // reset holds everything idle
    repeat (3) begin
      tick();
      chk("rst_en", 64'(en0), 64'd0);
      chk("rst_idx", 64'(idx0), 64'd0);
      chk("rst_data", 64'(data0), 64'd0);
      chk("rst_rdy", 64'(rdy0), 64'hF);
      chk("rst_en_fp", 64'(en1), 64'd0);
    end
    rst_in = 1'b1;
    tick();
    v0 = '0; v1 = '0;
    chk("lat_en1", 64'(en0), 64'd0);
    tick();
    chk("lat_en2", 64'(en0), 64'd1);
    chk("lat_src", 64'(src0), 64'd0);
    chk("lat_src_fp", 64'(src1), 64'd0);
    repeat (4) tick();
    chk("lat_idle", 64'(en0), 64'd0);

    // round robin across four simultaneous pushes
    for (int i = 0; i < 4; i++) drv(i, 32'hA0 + 32'(i));
    tick();
    v0 = '0; v1 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_en", 64'(en0), 64'd1);
      chk("rr_src", 64'(src0), 64'(k));
      chk("rr_idx", 64'(idx0), 64'(k));
      chk("rr_data", 64'(data0), 64'h0A0 + 64'(k));
    end
    tick();
    chk("rr_idle", 64'(en0), 64'd0);

    // lone source 2 moves the pointer to 3
    drv(2, 32'hC2);
    tick();
    v0 = '0; v1 = '0;
    tick();
    chk("rr2_src", 64'(src0), 64'd2);
    chk("rr2_data", 64'(data0), 64'hC2);
    for (int i = 0; i < 4; i++) drv(i, 32'hB0 + 32'(i));
    tick();
    v0 = '0; v1 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr3_src", 64'(src0), 64'(ord[k]));
      chk("rr3_data", 64'(data0), 64'h0B0 + 64'(ord[k]));
      chk("fp_order", 64'(src1), 64'(k));
    end
    tick();

    // continuous source 1 streams without backpressure
    for (int k = 1; k <= 20; k++) begin
      drv(1, 32'(k));
      tick();
      chk("bp_rdy", 64'(rdy0[1]), 64'd1);
      chk("bp_rdy_fp", 64'(rdy1[1]), 64'd1);
      if (k >= 2) chk("bp_data", 64'(data0), 64'(k - 1));
    end
    v0 = '0; v1 = '0;
    tick();
    chk("bp_last", 64'(data0), 64'd20);
    tick();
    chk("bp_idle", 64'(en0), 64'd0);

    // fixed priority: source 0 starves source 3
    log1.delete();
    n3 = 0;
    for (int k = 0; k < 8; k++) begin
      drv(0, 32'h300 + 32'(k));
      drv(3, 32'h400 + 32'(n3));
      tick();
      if (v1[3]) n3++;
      if (k >= 1) chk("fp_src0", 64'(src1), 64'd0);
    end
    chk("fp_rdy3", 64'(rdy1[3]), 64'd0);
    chk("fp_n3", 64'(n3), 64'd2);
    v0 = '0; v1 = '0;
    repeat (6) tick();
    chk("fp_size", 64'(log1.size() >= 3), 64'd1);
    if (log1.size() >= 3) begin
      chk("fp_tail0", 64'(log1[log1.size()-3]), {30'd0, 2'd0, 32'h307});
      chk("fp_tail1", 64'(log1[log1.size()-2]), {30'd0, 2'd3, 32'h400});
      chk("fp_tail2", 64'(log1[log1.size()-1]), {30'd0, 2'd3, 32'h401});
    end

    // flush drops everything in flight, including a same-cycle push
    for (int r = 0; r < 2; r++) begin
      drv(0, 32'h600 + 32'(r));
      drv(1, 32'h610 + 32'(r));
      tick();
    end
    v0 = '0; v1 = '0;
    flush_signal = 1'b1;
    drv(2, 32'hDEAD);
    tick();
    flush_signal = 1'b0;
    v0 = '0; v1 = '0;
    chk("fl_en", 64'(en0), 64'd0);
    chk("fl_en_fp", 64'(en1), 64'd0);
    chk("fl_rdy", 64'(rdy0), 64'hF);
    chk("fl_rdy_fp", 64'(rdy1), 64'hF);
    repeat (4) begin
      tick();
      chk("fl_quiet", 64'(en0), 64'd0);
      chk("fl_quiet_fp", 64'(en1), 64'd0);
    end

    // pause freezes the CDB with three entries pending
    for (int i = 0; i < 4; i++) drv(i, 32'h55 + 32'(i));
    tick();
    v0 = '0; v1 = '0;
    tick();
    rdy_in = 1'b0;
    ix[0] = 3'd0; dt[0] = 32'hBAD; v0[0] = 1'b1; v1[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("ps_en", 64'(en0), 64'd1);
      chk("ps_data", 64'(data0), 64'h55);
      chk("ps_rdy", 64'(rdy0), 64'hF);
      chk("ps_data_fp", 64'(data1), 64'h55);
    end
    v0 = '0; v1 = '0;
    rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ps_drain", 64'(data0), 64'h56 + 64'(k));
      chk("ps_src", 64'(src0), 64'(k + 1));
      chk("ps_drain_fp", 64'(data1), 64'h56 + 64'(k));
    end
    tick();
    chk("ps_idle", 64'(en0), 64'd0);
    tick();

    for (int q = 0; q < 8; q++) chk("sb_left", 64'(sb[q].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
